// File: rtl/gf2_poly_divider.sv
// ---------------------------------------------------------------------------
// gf2_poly_divider
//
// Bit-serial polynomial divider over GF(2)[x]. Given a dividend a(x) of up to
// degree 2N-2 and a divisor d(x) of up to degree N-1, it produces q(x) and
// r(x) such that a = q*d ^ r with deg(r) < deg(d). All arithmetic is XOR,
// so there are no carries anywhere in the datapath.
//
// Operation is split in three phases:
//   NORM   : shift the divisor left until its top bit is set, counting the
//            shift amount s = N-1-deg(d). A zero divisor exits here.
//   DIV    : classic restoring-free long division with a normalised divisor,
//            feeding a(x)*x^s MSB first (dividend bits followed by s zeros).
//   DENORM : the partial remainder holds r*x^s; shift it back down by s.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   rst          : synchronous active-high reset, overrides start
//   start        : request, accepted only while idle or done
//   dividend     : a(x), 2N-1 bits, bit i = coefficient of x^i
//   divisor      : d(x), N bits
//   busy         : high while normalising, dividing or denormalising
//   done         : high while the result registers are valid
//   div_by_zero  : valid with done, set when the divisor was zero
//   quotient     : q(x), 2N-1 bits
//   remainder    : r(x), N-1 bits
// ---------------------------------------------------------------------------
module gf2_poly_divider #(
    parameter int N = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-2:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [2*N-2:0]   quotient,
    output logic [N-2:0]     remainder
);

    localparam int AW = 2 * N - 1;
    localparam int RW = N - 1;
    // Counter must reach 2N-2+s (s <= N-1) without wrapping.
    localparam int CW = $clog2(3 * N);
    localparam int SW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_DIV,
        S_DENORM,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   dvd_q, dvd_d;
    logic [N-1:0]    dsr_q, dsr_d;
    logic [RW-1:0]   prem_q, prem_d;
    logic [AW-1:0]   quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   shamt_q, shamt_d;
    logic [AW-1:0]   quotient_q, quotient_d;
    logic [RW-1:0]   remainder_q, remainder_d;
    logic            dbz_q, dbz_d;

    logic [N-1:0]    step_v;
    logic            step_qb;

    // State and datapath registers; reset clears every visible output so
    // nothing reads as don't-care before the first completed division.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            shamt_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            shamt_q     <= shamt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Next-state and datapath logic for all phases.
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        shamt_d     = shamt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        // One long-division step: bring the next dividend bit into the
        // partial remainder; its top bit is the quotient bit and decides
        // whether the normalised divisor is subtracted (XORed) out.
        step_v  = {prem_q, dvd_q[AW-1]};
        step_qb = step_v[N-1];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvd_d       = dividend;
                    dsr_d       = divisor;
                    prem_d      = '0;
                    quo_d       = '0;
                    cnt_d       = '0;
                    shamt_d     = '0;
                    quotient_d  = '0;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    state_d     = S_NORM;
                end
            end

            S_NORM: begin
                if (dsr_q == '0) begin
                    dbz_d       = 1'b1;
                    quotient_d  = '0;
                    remainder_d = '0;
                    state_d     = S_DONE;
                end else if (dsr_q[N-1]) begin
                    // DIV runs 2N-1+s steps; count down to zero inclusive.
                    cnt_d   = CW'(AW - 1) + CW'(shamt_q);
                    state_d = S_DIV;
                end else begin
                    dsr_d   = dsr_q << 1;
                    shamt_d = shamt_q + SW'(1);
                end
            end

            S_DIV: begin
                prem_d = step_v[N-2:0] ^ (step_qb ? dsr_q[N-2:0] : '0);
                quo_d  = {quo_q[AW-2:0], step_qb};
                // Shifting zeros in supplies the trailing s zero bits of a*x^s.
                dvd_d  = dvd_q << 1;
                if (cnt_q == '0) begin
                    cnt_d   = CW'(shamt_q);
                    state_d = S_DENORM;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            S_DENORM: begin
                if (cnt_q != '0) begin
                    prem_d = prem_q >> 1;
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    quotient_d  = quo_q;
                    remainder_d = prem_q;
                    state_d     = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_NORM) || (state_q == S_DIV) || (state_q == S_DENORM);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// ---------------------------------------------------------------------------
// tb_gf2_poly_divider
//
// Self-checking bench for gf2_poly_divider at N=64 and N=8. Expected results
// come from a textbook polynomial long-division model working on whole
// vectors, a carry-less multiply round trip, and the closed-form latency.
// ---------------------------------------------------------------------------
module tb_gf2_poly_divider;

    logic clk;
    logic rst;

    logic         start64;
    logic [126:0] dividend64;
    logic [63:0]  divisor64;
    logic         busy64, done64, dbz64;
    logic [126:0] quotient64;
    logic [62:0]  remainder64;

    logic         start8;
    logic [14:0]  dividend8;
    logic [7:0]   divisor8;
    logic         busy8, done8, dbz8;
    logic [14:0]  quotient8;
    logic [6:0]   remainder8;

    int check_count;
    int pass_count;

    gf2_poly_divider #(.N(64)) dut64 (
        .clk         (clk),
        .rst         (rst),
        .start       (start64),
        .dividend    (dividend64),
        .divisor     (divisor64),
        .busy        (busy64),
        .done        (done64),
        .div_by_zero (dbz64),
        .quotient    (quotient64),
        .remainder   (remainder64)
    );

    gf2_poly_divider #(.N(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .dividend    (dividend8),
        .divisor     (divisor8),
        .busy        (busy8),
        .done        (done8),
        .div_by_zero (dbz8),
        .quotient    (quotient8),
        .remainder   (remainder8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        check_count++;
        if (got !== exp)
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        else
            pass_count++;
    endtask

    // Degree of a polynomial, -1 for the zero polynomial.
    function automatic int deg(input logic [127:0] x);
        for (int i = 127; i >= 0; i--)
            if (x[i]) return i;
        return -1;
    endfunction

    // Schoolbook long division: cancel the leading term of r repeatedly.
    function automatic void poly_div(input logic [127:0] a, input logic [127:0] d,
                                     output logic [127:0] q, output logic [127:0] r);
        int dd;
        dd = deg(d);
        q  = '0;
        r  = a;
        if (dd < 0) begin
            r = '0;
            return;
        end
        for (int i = 127; i >= dd; i--) begin
            if (r[i]) begin
                q[i-dd] = 1'b1;
                r       = r ^ (d << (i - dd));
            end
        end
    endfunction

    function automatic logic [127:0] clmul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 128; i++)
            if (b[i]) res = res ^ (a << i);
        return res;
    endfunction

    function automatic logic [126:0] rand127();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[126:0];
    endfunction

    // Random nonzero divisor with uniformly chosen degree.
    function automatic logic [63:0] rand_div64();
        int          k;
        logic [63:0] x;
        logic [63:0] one;
        one = 64'h1;
        k   = $urandom_range(0, 63);
        x   = {$urandom(), $urandom()};
        x   = (x & ((one << k) - one)) | (one << k);
        return x;
    endfunction

    // Compare one finished division against the reference model.
    task automatic checkResult(input string tag, input int n, input logic [127:0] a,
                               input logic [127:0] d, input logic [127:0] q,
                               input logic [127:0] r, input logic dz, input int lat);
        logic [127:0] eq, er;
        int exp_lat;
        poly_div(a, d, eq, er);
        exp_lat = (deg(d) < 0) ? 1 : (2 * n + 1 + 3 * (n - 1 - deg(d)));
        checkOutput({tag, "_q"},   q, eq);
        checkOutput({tag, "_r"},   r, er);
        checkOutput({tag, "_dbz"}, 128'(dz), 128'(d == '0));
        checkOutput({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        if (d != '0) begin
            checkOutput({tag, "_roundtrip"}, clmul(q, d) ^ r, a);
            checkOutput({tag, "_degr"}, 128'(deg(r) < deg(d)), 128'(1));
        end
    endtask

    // Launch one division on the N=64 instance and measure accept-to-done.
    task automatic applyStimulus64(input logic [126:0] a, input logic [63:0] d, output int lat);
        @(negedge clk);
        start64    = 1'b1;
        dividend64 = a;
        divisor64  = d;
        @(posedge clk);
        #1;
        start64 = 1'b0;
        lat     = 0;
        while (!done64 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic applyStimulus8(input logic [14:0] a, input logic [7:0] d, output int lat);
        @(negedge clk);
        start8    = 1'b1;
        dividend8 = a;
        divisor8  = d;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat    = 0;
        while (!done8 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int           lat;
        logic [126:0] a1;
        logic [63:0]  d1;

        check_count = 0;
        pass_count  = 0;
        rst         = 1'b1;
        start64     = 1'b0;
        dividend64  = '0;
        divisor64   = '0;
        start8      = 1'b0;
        dividend8   = '0;
        divisor8    = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_busy", 128'(busy64), 128'(0));
        checkOutput("reset_done", 128'(done64), 128'(0));
        checkOutput("reset_dbz",  128'(dbz64), 128'(0));
        checkOutput("reset_q",    128'(quotient64), 128'(0));
        checkOutput("reset_r",    128'(remainder64), 128'(0));

        // x^2+x+1 / (x+1)
        applyStimulus64(127'h7, 64'h3, lat);
        checkOutput("t1_q",   128'(quotient64), 128'h2);
        checkOutput("t1_r",   128'(remainder64), 128'h1);
        checkOutput("t1_dbz", 128'(dbz64), 128'(0));
        checkOutput("t1_lat", 128'(lat), 128'(315));

        // All-ones dividend by x^63
        applyStimulus64({127{1'b1}}, 64'h8000_0000_0000_0000, lat);
        checkOutput("t2_q",   128'(quotient64), 128'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t2_r",   128'(remainder64), 128'h7FFF_FFFF_FFFF_FFFF);
        checkOutput("t2_lat", 128'(lat), 128'(129));

        // AES-style reduction, then division by 1
        applyStimulus64(127'h100, 64'h11B, lat);
        checkOutput("t3_q", 128'(quotient64), 128'h1);
        checkOutput("t3_r", 128'(remainder64), 128'h1B);
        a1 = rand127();
        a1[126] = 1'b1;
        applyStimulus64(a1, 64'h1, lat);
        checkOutput("t3b_q",   128'(quotient64), 128'(a1));
        checkOutput("t3b_r",   128'(remainder64), 128'(0));
        checkOutput("t3b_lat", 128'(lat), 128'(318));

        // Zero divisor, then a normal division clears the flag
        a1 = rand127();
        applyStimulus64(a1, 64'h0, lat);
        checkResult("t4", 64, 128'(a1), 128'(0), 128'(quotient64), 128'(remainder64), dbz64, lat);
        applyStimulus64(a1, 64'h11B, lat);
        checkOutput("t4_dbz_clear", 128'(dbz64), 128'(0));

        // start during DIV must be ignored
        a1 = rand127();
        d1 = 64'h8000_0000_0000_0005;
        @(negedge clk);
        start64    = 1'b1;
        dividend64 = a1;
        divisor64  = d1;
        @(posedge clk);
        #1;
        start64 = 1'b0;
        lat     = 0;
        while (!done64 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 60) begin
                start64    = 1'b1;
                dividend64 = rand127();
                divisor64  = 64'h3;
            end else begin
                start64 = 1'b0;
            end
        end
        checkResult("t5", 64, 128'(a1), 128'(d1), 128'(quotient64), 128'(remainder64), dbz64, lat);

        // Reset in the middle of DIV aborts the operation
        @(negedge clk);
        start64    = 1'b1;
        dividend64 = rand127();
        divisor64  = d1;
        @(posedge clk);
        #1;
        start64 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("t5_rst_busy", 128'(busy64), 128'(0));
        checkOutput("t5_rst_done", 128'(done64), 128'(0));
        checkOutput("t5_rst_dbz",  128'(dbz64), 128'(0));
        checkOutput("t5_rst_q",    128'(quotient64), 128'(0));
        checkOutput("t5_rst_r",    128'(remainder64), 128'(0));
        a1 = rand127();
        d1 = rand_div64();
        applyStimulus64(a1, d1, lat);
        checkResult("t5b", 64, 128'(a1), 128'(d1), 128'(quotient64), 128'(remainder64), dbz64, lat);

        // Random pairs on both widths in parallel
        fork
            begin
                int           l64;
                logic [126:0] ra;
                logic [63:0]  rd;
                for (int i = 0; i < 200; i++) begin
                    ra = rand127();
                    rd = rand_div64();
                    applyStimulus64(ra, rd, l64);
                    checkResult("r64", 64, 128'(ra), 128'(rd), 128'(quotient64),
                                128'(remainder64), dbz64, l64);
                end
            end
            begin
                int          l8;
                logic [14:0] ra8;
                logic [7:0]  rd8;
                for (int i = 0; i < 2000; i++) begin
                    ra8 = 15'($urandom_range(0, 32767));
                    rd8 = 8'($urandom_range(1, 255));
                    applyStimulus8(ra8, rd8, l8);
                    checkResult("r8", 8, 128'(ra8), 128'(rd8), 128'(quotient8),
                                128'(remainder8), dbz8, l8);
                end
            end
        join

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
